// File: rtl/mcu_dct_scheduler_pkg.sv
// Shared constants for the MCU/DCT strip scheduler: capture-field geometry,
// strip/MCU counts and FSM state codes.
package mcu_sched_pkg;

    localparam int unsigned X0          = 208;
    localparam int unsigned Y0          = 128;
    localparam int unsigned FIELD       = 224;
    localparam int unsigned MCU_DIM     = 8;
    localparam int unsigned NUM_MCUS    = FIELD / MCU_DIM;
    localparam int unsigned NUM_STRIPS  = 28;
    localparam int unsigned SEL_W       = 5;
    localparam int unsigned DCT_TIMEOUT = 64;
    localparam int unsigned STATE_W     = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_CAPTURE  = 3'd1;
    localparam logic [STATE_W-1:0] ST_ISSUE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_DCT = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD     = 3'd4;

endpackage

// File: rtl/mcu_dct_scheduler_watchdog.sv
// DCT job watchdog: counts cycles while enabled and flags the cycle on which
// the count steps onto DCT_TIMEOUT-1.
module dct_watchdog #(
    parameter int unsigned DCT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(DCT_TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Decision cycle is the one whose increment would land on DCT_TIMEOUT-1.
    assign expire = enable && (count == CNT_W'(DCT_TIMEOUT - 2));

endmodule

// File: rtl/mcu_dct_scheduler.sv
// Steps one captured 8-row strip through the shared DCT engine, one MCU job at
// a time, holding each result until the CSR reader acknowledges it.
module mcu_dct_scheduler
    import mcu_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [SEL_W-1:0] strip_in,
    input  logic             abort,
    input  logic             clr_err,
    input  logic             strip_done,
    input  logic             dct_done,
    input  logic             result_ack,
    output logic             capture_en,
    output logic [SEL_W-1:0] strip_number,
    output logic [SEL_W-1:0] mcu_sel,
    output logic             dct_start,
    output logic             result_valid,
    output logic             strip_complete,
    output logic             busy,
    output logic             err_busy,
    output logic             err_range,
    output logic             err_timeout
);

    logic [STATE_W-1:0] state, state_nxt;
    logic [SEL_W-1:0]   strip_nxt, sel_nxt;
    logic               complete_nxt;
    logic               err_busy_nxt, err_range_nxt, err_timeout_nxt;
    logic               wd_expire;

    dct_watchdog #(.DCT_TIMEOUT(DCT_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT_DCT),
        .expire  (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            strip_number   <= '0;
            mcu_sel        <= '0;
            strip_complete <= 1'b0;
            err_busy       <= 1'b0;
            err_range      <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= state_nxt;
            strip_number   <= strip_nxt;
            mcu_sel        <= sel_nxt;
            strip_complete <= complete_nxt;
            err_busy       <= err_busy_nxt;
            err_range      <= err_range_nxt;
            err_timeout    <= err_timeout_nxt;
        end
    end

    // Abort overrides everything and leaves the sticky flags untouched.
    always_comb begin
        state_nxt       = state;
        strip_nxt       = strip_number;
        sel_nxt         = mcu_sel;
        complete_nxt    = 1'b0;
        err_busy_nxt    = clr_err ? 1'b0 : err_busy;
        err_range_nxt   = clr_err ? 1'b0 : err_range;
        err_timeout_nxt = clr_err ? 1'b0 : err_timeout;

        if (abort) begin
            state_nxt       = ST_IDLE;
            sel_nxt         = '0;
            err_busy_nxt    = err_busy;
            err_range_nxt   = err_range;
            err_timeout_nxt = err_timeout;
        end else begin
            if (start && (state != ST_IDLE)) begin
                err_busy_nxt = 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (strip_in < SEL_W'(NUM_STRIPS)) begin
                            strip_nxt = strip_in;
                            sel_nxt   = '0;
                            state_nxt = ST_CAPTURE;
                        end else begin
                            err_range_nxt = 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (strip_done) begin
                        state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: state_nxt = ST_WAIT_DCT;
                ST_WAIT_DCT: begin
                    if (dct_done) begin
                        state_nxt = ST_HOLD;
                    end else if (wd_expire) begin
                        state_nxt       = ST_IDLE;
                        sel_nxt         = '0;
                        err_timeout_nxt = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (result_ack) begin
                        if (mcu_sel == SEL_W'(NUM_MCUS - 1)) begin
                            complete_nxt = 1'b1;
                            sel_nxt      = '0;
                            state_nxt    = ST_IDLE;
                        end else begin
                            sel_nxt   = mcu_sel + SEL_W'(1);
                            state_nxt = ST_ISSUE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign capture_en   = (state == ST_CAPTURE);
    assign dct_start    = (state == ST_ISSUE);
    assign result_valid = (state == ST_HOLD);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_mcu_dct_scheduler.sv
// Directed bench for mcu_dct_scheduler: a cycle-level reference of the strip
// sequencing rules is compared against every output on each falling edge.
module tb_mcu_dct_scheduler;

    localparam int N_MCU   = 28;
    localparam int N_STRIP = 28;
    localparam int TMO     = 64;
    localparam int P_IDLE = 0, P_CAP = 1, P_ISSUE = 2, P_WAIT = 3, P_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, clr_err = 1'b0;
    logic       strip_done = 1'b0, dct_done = 1'b0, result_ack = 1'b0;
    logic [4:0] strip_in = '0;
    logic       capture_en, dct_start, result_valid, strip_complete, busy;
    logic       err_busy, err_range, err_timeout;
    logic [4:0] strip_number, mcu_sel;

    always #5 clk = ~clk;

    mcu_dct_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .strip_in       (strip_in),
        .abort          (abort),
        .clr_err        (clr_err),
        .strip_done     (strip_done),
        .dct_done       (dct_done),
        .result_ack     (result_ack),
        .capture_en     (capture_en),
        .strip_number   (strip_number),
        .mcu_sel        (mcu_sel),
        .dct_start      (dct_start),
        .result_valid   (result_valid),
        .strip_complete (strip_complete),
        .busy           (busy),
        .err_busy       (err_busy),
        .err_range      (err_range),
        .err_timeout    (err_timeout)
    );

    int n_cmp = 0, n_bad = 0;
    int n_complete = 0, n_issue = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase of the strip job, MCU index, cycles since the job started.
    int m_phase = P_IDLE, m_sel = 0, m_strip = 0, m_since = 0;
    bit m_cmp = 1'b0, m_er = 1'b0, m_eb = 1'b0, m_et = 1'b0;

    always @(posedge clk) begin : model
        int ph, sl, st, sn;
        bit cp, er, eb, et;
        ph = m_phase; sl = m_sel; st = m_strip; sn = m_since;
        cp = 1'b0; er = m_er; eb = m_eb; et = m_et;
        if (!reset_n) begin
            ph = P_IDLE; sl = 0; st = 0; sn = 0; er = 0; eb = 0; et = 0;
        end else if (abort) begin
            ph = P_IDLE; sl = 0;
        end else begin
            if (clr_err) begin er = 0; eb = 0; et = 0; end
            if (start && m_phase != P_IDLE) eb = 1;
            if (m_phase == P_IDLE && start) begin
                if (int'(strip_in) < N_STRIP) begin st = int'(strip_in); sl = 0; ph = P_CAP; end
                else er = 1;
            end else if (m_phase == P_CAP && strip_done) begin
                ph = P_ISSUE;
            end else if (m_phase == P_ISSUE) begin
                ph = P_WAIT; sn = 1;
            end else if (m_phase == P_WAIT) begin
                if (dct_done) ph = P_HOLD;
                else if (m_since == TMO - 1) begin ph = P_IDLE; sl = 0; et = 1; end
                else sn = m_since + 1;
            end else if (m_phase == P_HOLD && result_ack) begin
                if (m_sel == N_MCU - 1) begin cp = 1; sl = 0; ph = P_IDLE; end
                else begin sl = m_sel + 1; ph = P_ISSUE; end
            end
        end
        m_phase <= ph; m_sel <= sl; m_strip <= st; m_since <= sn;
        m_cmp <= cp; m_er <= er; m_eb <= eb; m_et <= et;
    end

    always @(negedge clk) begin
        if (strip_complete) n_complete++;
        if (dct_start) n_issue++;
        if (cmp_en) begin
            check("capture_en",     capture_en,     int'(m_phase == P_CAP));
            check("dct_start",      dct_start,      int'(m_phase == P_ISSUE));
            check("result_valid",   result_valid,   int'(m_phase == P_HOLD));
            check("busy",           busy,           int'(m_phase != P_IDLE));
            check("mcu_sel",        mcu_sel,        m_sel);
            check("strip_number",   strip_number,   m_strip);
            check("strip_complete", strip_complete, m_cmp);
            check("err_busy",       err_busy,       m_eb);
            check("err_range",      err_range,      m_er);
            check("err_timeout",    err_timeout,    m_et);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start(input logic [4:0] s);
        start = 1'b1; strip_in = s; tick(); start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    task automatic capture_done();
        strip_done = 1'b1; tick(); strip_done = 1'b0;
    endtask

    task automatic wait_issue(input int exp_sel);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (dct_start) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) check("dct_start_wait_expired", 0, 1);
        else check("issue_mcu_sel", mcu_sel, exp_sel);
    endtask

    // One MCU job: done dly cycles after dct_start, result reaches HOLD.
    task automatic job_to_hold(input int exp_sel, input int dly);
        wait_issue(exp_sel);
        tick(dly);
        dct_done = 1'b1; tick(); dct_done = 1'b0;
    endtask

    task automatic run_mcu(input int exp_sel);
        job_to_hold(exp_sel, 4);
        tick(2);
        result_ack = 1'b1; tick(); result_ack = 1'b0;
    endtask

    task automatic run_strip(input logic [4:0] s);
        int issue0, comp0;
        issue0 = n_issue; comp0 = n_complete;
        pulse_start(s);
        check("capture_en_after_start", capture_en, 1);
        check("strip_latched", strip_number, int'(s));
        tick(2);
        capture_done();
        check("dct_start_after_strip_done", dct_start, 1);
        for (int i = 0; i < N_MCU; i++) run_mcu(i);
        check("strip_complete_pulse", strip_complete, 1);
        check("idle_after_strip", busy, 0);
        tick();
        check("strip_complete_one_cycle", strip_complete, 0);
        check("issues_per_strip", n_issue - issue0, N_MCU);
        check("completes_per_strip", n_complete - comp0, 1);
    endtask

    initial begin
        int cnt, comp0;
        tick(2);
        check("reset_busy", busy, 0);
        check("reset_mcu_sel", mcu_sel, 0);
        check("reset_strip_number", strip_number, 0);
        cmp_en = 1'b1;
        reset_n = 1'b1;
        tick();

        // Out-of-range strip, then clear.
        pulse_start(5'd28);
        check("range_err_set", err_range, 1);
        check("range_stays_idle", busy, 0);
        pulse_clr();
        check("range_err_cleared", err_range, 0);

        // Start while capturing.
        pulse_start(5'd5);
        pulse_start(5'd9);
        check("busy_err_set", err_busy, 1);
        check("busy_strip_kept", strip_number, 5);
        pulse_abort();
        pulse_clr();

        run_strip(5'd3);

        // Watchdog expiry on the third MCU.
        comp0 = n_complete;
        pulse_start(5'd0);
        capture_done();
        run_mcu(0);
        run_mcu(1);
        wait_issue(2);
        cnt = 0;
        while (!err_timeout && cnt < 200) begin tick(); cnt++; end
        check("timeout_latency", cnt, TMO);
        check("timeout_idle", busy, 0);
        check("timeout_no_complete", n_complete - comp0, 0);
        pulse_clr();

        // dct_done on the last allowed cycle is accepted.
        pulse_start(5'd4);
        capture_done();
        job_to_hold(0, TMO - 1);
        check("late_done_hold", result_valid, 1);
        check("late_done_no_err", err_timeout, 0);
        pulse_abort();

        // Abort while holding MCU 10.
        pulse_start(5'd2);
        capture_done();
        for (int i = 0; i < 10; i++) run_mcu(i);
        job_to_hold(10, 4);
        check("hold_at_10", mcu_sel, 10);
        pulse_abort();
        check("abort_busy", busy, 0);
        check("abort_mcu_sel", mcu_sel, 0);
        check("abort_result_valid", result_valid, 0);
        run_strip(5'd1);

        // Reset during WAIT_DCT, then stray handshakes in IDLE.
        pulse_start(5'd7);
        capture_done();
        wait_issue(0);
        tick(2);
        reset_n = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_strip_number", strip_number, 0);
        reset_n = 1'b1;
        dct_done = 1'b1; result_ack = 1'b1; strip_done = 1'b1;
        tick();
        dct_done = 1'b0; result_ack = 1'b0; strip_done = 1'b0;
        check("stray_idle", busy, 0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcu_dct_scheduler.md
Name: mcu_dct_scheduler

Overview:
Sequences one 8-row capture strip (28 MCUs across the 224-pixel capture field) through the single shared DCT/quantisation engine.
- Arms pixel capture for the requested strip.
- Once the strip is fully captured, steps the MCU select through 0..27, issuing one DCT job per MCU.
- Holds each result for the Avalon reader until acknowledged.
- Sits between the Avalon CSR slave (start, strip, ack) and the MCU buffer / DCT datapath (capture enable, strip number, MCU select).

Parameters:
NUM_MCUS, 28, MCUs per strip; mcu_sel counts 0..NUM_MCUS-1.
NUM_STRIPS, 28, valid strip numbers 0..NUM_STRIPS-1.
SEL_W, 5, width of mcu_sel and strip fields.
DCT_TIMEOUT, 64, maximum cycles in WAIT_DCT before timeout abort.

Ports:
clk  in  1  system clock (100 MHz)
reset_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse from CSR write; begins a strip
strip_in  in  SEL_W  strip number to capture, sampled with start
abort  in  1  one-cycle pulse; return to IDLE from any state
clr_err  in  1  one-cycle pulse; clears sticky error flags
strip_done  in  1  capture logic saw the last pixel of the armed strip
dct_done  in  1  DCT engine result valid for the issued job
result_ack  in  1  Avalon reader consumed the current result
capture_en  out  1  enables pixel capture into the MCU buffer
strip_number  out  SEL_W  latched strip number for the capture window
mcu_sel  out  SEL_W  MCU index driven to the DCT input mux
dct_start  out  1  one-cycle job-start pulse to the DCT engine
result_valid  out  1  current DCT result is held and readable
strip_complete  out  1  one-cycle pulse after the last MCU is acknowledged
busy  out  1  high in every state except IDLE
err_busy  out  1  sticky: start received while busy
err_range  out  1  sticky: start with strip_in >= NUM_STRIPS
err_timeout  out  1  sticky: DCT watchdog expired

Behaviour:
- Reset (sampled on posedge clk with reset_n=0): state=IDLE; all outputs 0; strip_number=0; mcu_sel=0; watchdog=0. Reset overrides every other input.
- Outputs are decoded from registered state/counters:
  - capture_en = (state==CAPTURE)
  - dct_start = (state==ISSUE)
  - result_valid = (state==HOLD)
  - busy = (state!=IDLE)
- IDLE:
  - start with strip_in < NUM_STRIPS: latch strip_number, clear mcu_sel, go to CAPTURE. capture_en rises the cycle after start.
  - start with strip_in >= NUM_STRIPS: set err_range, stay in IDLE.
  - strip_done, dct_done and result_ack are ignored.
- CAPTURE: on strip_done, go to ISSUE. dct_start is high exactly the cycle after strip_done is sampled.
- ISSUE: lasts exactly one cycle, then WAIT_DCT with watchdog cleared.
- WAIT_DCT:
  - Watchdog increments each cycle.
  - dct_done: go to HOLD.
  - Watchdog reaches DCT_TIMEOUT-1 without dct_done: set err_timeout, go to IDLE, no strip_complete.
  - dct_done and the timeout in the same cycle: dct_done wins.
- HOLD:
  - result_valid stays high until result_ack.
  - result_ack with mcu_sel < NUM_MCUS-1: mcu_sel += 1, go to ISSUE.
  - result_ack with mcu_sel == NUM_MCUS-1: pulse strip_complete for one cycle, mcu_sel=0, go to IDLE.
- result_ack outside HOLD is ignored.
- start while busy: ignored; set err_busy; strip_number is not changed.
- abort in any state: next state IDLE, mcu_sel=0, no strip_complete, error flags unchanged. abort wins over every other event in the same cycle.
- clr_err: clears all three sticky flags next cycle. If the same cycle also sets a flag, the set wins.
- mcu_sel never exceeds NUM_MCUS-1. strip_number is held stable from CAPTURE through the last HOLD.

Decomposition:
- Package mcu_sched_pkg holds:
  - state enum {IDLE, CAPTURE, ISSUE, WAIT_DCT, HOLD}
  - NUM_MCUS, NUM_STRIPS
  - capture-field constants: X0=208, Y0=128, FIELD=224, MCU_DIM=8
- One sub-module: dct_watchdog (clear, enable, expire), a counter parameterised by DCT_TIMEOUT.

Test Plan:
- Full strip: start, strip_in=3 → capture_en=1 next cycle, strip_number=3. strip_done → dct_start the next cycle. Return dct_done 4 cycles after each dct_start and ack 2 cycles after each result_valid → 28 dct_start pulses with mcu_sel 0..27, one strip_complete, then IDLE with busy=0.
- Range error: start, strip_in=28 → err_range=1, busy=0. Then clr_err → err_range=0.
- Busy error: start, strip_in=5, then start, strip_in=9 during CAPTURE → err_busy=1, strip_number remains 5.
- Timeout: withhold dct_done after mcu 2's dct_start → err_timeout=1 exactly 64 cycles later, state IDLE, no strip_complete. Also check dct_done on cycle 63 is accepted with no error.
- Abort: abort in HOLD at mcu_sel=10 → next cycle busy=0, mcu_sel=0, result_valid=0. A following start, strip_in=1 runs normally.
- Reset mid-operation: reset_n=0 during WAIT_DCT → all outputs 0 next edge. Stray dct_done and result_ack in IDLE produce no state change.
